// File: rtl/icache_line_refill.sv
// Instruction-cache line refill controller.
// Takes one line miss and issues one line-read request to next-level memory.
// It collects the narrow response beats into a line buffer, then writes the
// whole line to the cache data memory in a single cycle.
// Optional feature macro: ICACHE_CRITICAL_WORD_FIRST_EN. When it is defined,
// the request is beat-aligned, the beats wrap starting at the critical word,
// and the first beat is forwarded on the critical-word outputs.
module icache_line_refill #(
    parameter  int LINE_WIDTH = 512,
    parameter  int BEAT_WIDTH = 32,
    parameter  int ADDR_WIDTH = 32,
    parameter  int LINE_DEPTH = 512,
    localparam int BEATS      = LINE_WIDTH / BEAT_WIDTH,
    localparam int OFFSET_W   = $clog2(LINE_WIDTH / 8),
    localparam int INDEX_W    = $clog2(LINE_DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_miss_valid,
    input  logic [ADDR_WIDTH-1:0] i_miss_address,
    output logic                  o_miss_ready,
    output logic                  o_mem_req_valid,
    output logic [ADDR_WIDTH-1:0] o_mem_req_address,
    input  logic                  i_mem_req_ready,
    input  logic                  i_mem_resp_valid,
    input  logic [BEAT_WIDTH-1:0] i_mem_resp_data,
    output logic                  o_line_write_enable,
    output logic [INDEX_W-1:0]    o_line_write_address,
    output logic [LINE_WIDTH-1:0] o_line_data,
    output logic                  o_refill_done,
    output logic                  o_critical_valid,
    output logic [BEAT_WIDTH-1:0] o_critical_data
);

    localparam int BOFF_W = $clog2(BEAT_WIDTH / 8);
    localparam int PTR_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CNT_W  = $clog2(BEATS) + 1;

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        RECEIVE,
        WRITE
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LINE_WIDTH-1:0] r_line;
    logic [PTR_W-1:0]      r_beat_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_miss_ready;
    logic                  r_req_valid;
    logic                  r_write_en;
    logic                  r_done;

    // Request address captured at acceptance: line-aligned normally,
    // beat-aligned when the critical word is fetched first.
    logic [ADDR_WIDTH-1:0] w_req_addr;
    logic                  w_unused;

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    assign w_req_addr = {i_miss_address[ADDR_WIDTH-1:BOFF_W], {BOFF_W{1'b0}}};
    assign w_unused   = &{1'b0, i_miss_address[BOFF_W-1:0]};
`else
    assign w_req_addr = {i_miss_address[ADDR_WIDTH-1:OFFSET_W], {OFFSET_W{1'b0}}};
    assign w_unused   = &{1'b0, i_miss_address[OFFSET_W-1:0]};
`endif

    // Main refill sequencer with all control outputs registered.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_line       <= '0;
            r_beat_ptr   <= '0;
            r_count      <= '0;
            r_miss_ready <= 1'b1;
            r_req_valid  <= 1'b0;
            r_write_en   <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_miss_valid) begin
                        r_addr       <= w_req_addr;
                        r_miss_ready <= 1'b0;
                        r_req_valid  <= 1'b1;
                        r_state      <= REQUEST;
                    end
                end
                REQUEST: begin
                    if (i_mem_req_ready) begin
                        // The beat offset bits of r_addr are zero unless the
                        // critical word is fetched first, so slot 0 is the default start.
                        r_beat_ptr  <= r_addr[OFFSET_W-1:BOFF_W];
                        r_count     <= '0;
                        r_req_valid <= 1'b0;
                        r_state     <= RECEIVE;
                    end
                end
                RECEIVE: begin
                    if (i_mem_resp_valid) begin
                        r_line[r_beat_ptr*BEAT_WIDTH +: BEAT_WIDTH] <= i_mem_resp_data;
                        if (r_beat_ptr == PTR_W'(BEATS - 1)) begin
                            r_beat_ptr <= '0;
                        end else begin
                            r_beat_ptr <= r_beat_ptr + 1'b1;
                        end
                        r_count <= r_count + 1'b1;
                        if (r_count == CNT_W'(BEATS - 1)) begin
                            r_write_en <= 1'b1;
                            r_done     <= 1'b1;
                            r_state    <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    r_write_en   <= 1'b0;
                    r_done       <= 1'b0;
                    r_miss_ready <= 1'b1;
                    r_state      <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    logic                  r_crit_valid;
    logic [BEAT_WIDTH-1:0] r_crit_data;
    logic                  w_first_beat;

    assign w_first_beat = (r_state == RECEIVE) && i_mem_resp_valid && (r_count == '0);

    // Forward the first returned beat one cycle after it is sampled.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_crit_valid <= 1'b0;
            r_crit_data  <= '0;
        end else begin
            r_crit_valid <= w_first_beat;
            if (w_first_beat) begin
                r_crit_data <= i_mem_resp_data;
            end
        end
    end

    assign o_critical_valid = r_crit_valid;
    assign o_critical_data  = r_crit_data;
`else
    assign o_critical_valid = 1'b0;
    assign o_critical_data  = '0;
`endif

    assign o_miss_ready         = r_miss_ready;
    assign o_mem_req_valid      = r_req_valid;
    assign o_mem_req_address    = r_addr;
    assign o_line_write_enable  = r_write_en;
    assign o_line_write_address = r_addr[OFFSET_W +: INDEX_W];
    assign o_line_data          = r_line;
    assign o_refill_done        = r_done;

endmodule

// File: tb/tb_icache_line_refill.sv
// Self-checking bench for icache_line_refill using a line-level reference model.
module tb_icache_line_refill;

    localparam int LW = 512;
    localparam int BW = 32;
    localparam int AW = 32;
    localparam int LD = 512;
    localparam int NB = LW / BW;

    logic          clk = 1'b0;
    logic          i_reset_n;
    logic          i_miss_valid;
    logic [AW-1:0] i_miss_address;
    logic          o_miss_ready;
    logic          o_mem_req_valid;
    logic [AW-1:0] o_mem_req_address;
    logic          i_mem_req_ready;
    logic          i_mem_resp_valid;
    logic [BW-1:0] i_mem_resp_data;
    logic          o_line_write_enable;
    logic [8:0]    o_line_write_address;
    logic [LW-1:0] o_line_data;
    logic          o_refill_done;
    logic          o_critical_valid;
    logic [BW-1:0] o_critical_data;

    int checks = 0;
    int errors = 0;
    int wr_count = 0;

    always #5 clk = ~clk;

    icache_line_refill #(
        .LINE_WIDTH(LW), .BEAT_WIDTH(BW), .ADDR_WIDTH(AW), .LINE_DEPTH(LD)
    ) dut (
        .i_clk               (clk),
        .i_reset_n           (i_reset_n),
        .i_miss_valid        (i_miss_valid),
        .i_miss_address      (i_miss_address),
        .o_miss_ready        (o_miss_ready),
        .o_mem_req_valid     (o_mem_req_valid),
        .o_mem_req_address   (o_mem_req_address),
        .i_mem_req_ready     (i_mem_req_ready),
        .i_mem_resp_valid    (i_mem_resp_valid),
        .i_mem_resp_data     (i_mem_resp_data),
        .o_line_write_enable (o_line_write_enable),
        .o_line_write_address(o_line_write_address),
        .o_line_data         (o_line_data),
        .o_refill_done       (o_refill_done),
        .o_critical_valid    (o_critical_valid),
        .o_critical_data     (o_critical_data)
    );

    // Count every data-memory write seen at mid-cycle.
    always @(negedge clk) begin
        if (o_line_write_enable === 1'b1) wr_count++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference rules: where the first beat lands, what is requested, which line is written.
    function automatic int start_slot(input logic [AW-1:0] a);
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
        return int'((a % 64) / 4);
`else
        return 0;
`endif
    endfunction

    function automatic logic [AW-1:0] req_addr_of(input logic [AW-1:0] a);
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
        return a - (a % 4);
`else
        return a - (a % 64);
`endif
    endfunction

    function automatic logic [8:0] index_of(input logic [AW-1:0] a);
        return 9'((a / 64) % LD);
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_miss_ready"}, o_miss_ready, 1);
        check({tag, "_req_valid"}, o_mem_req_valid, 0);
        check({tag, "_req_addr"}, o_mem_req_address, 0);
        check({tag, "_we"}, o_line_write_enable, 0);
        check({tag, "_wr_addr"}, o_line_write_address, 0);
        check({tag, "_line"}, o_line_data, 0);
        check({tag, "_done"}, o_refill_done, 0);
        check({tag, "_crit_v"}, o_critical_valid, 0);
        check({tag, "_crit_d"}, o_critical_data, 0);
    endtask

    // One complete refill. pattern=1 gives slot s the value 0x1000+s, otherwise random data.
    task automatic run_refill(input logic [AW-1:0] addr, input int rdy_delay, input int max_gap,
                              input bit stray, input bit hold_next, input logic [AW-1:0] next_addr,
                              input bit pattern);
        logic [BW-1:0] beats[NB];
        logic [LW-1:0] exp_line;
        int s, n, wr0, gap;
        s = start_slot(addr);
        exp_line = '0;
        for (int k = 0; k < NB; k++) begin
            beats[k] = pattern ? BW'(32'h1000 + ((s + k) % NB)) : BW'($urandom);
            exp_line[((s + k) % NB) * BW +: BW] = beats[k];
        end
        i_miss_valid   = 1'b1;
        i_miss_address = addr;
        if (stray) begin
            i_mem_resp_valid = 1'b1;
            i_mem_resp_data  = 32'hDEAD_BEEF;
        end
        n = 0;
        while (o_miss_ready !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        check("miss_ready_before_accept", o_miss_ready, 1);
        wr0 = wr_count;
        step();
        i_mem_resp_valid = 1'b0;
        if (hold_next) i_miss_address = next_addr;
        else i_miss_valid = 1'b0;
        check("req_valid", o_mem_req_valid, 1);
        check("req_addr", o_mem_req_address, req_addr_of(addr));
        check("miss_ready_busy", o_miss_ready, 0);
        for (int d = 0; d < rdy_delay; d++) begin
            i_mem_resp_valid = 1'b1;
            i_mem_resp_data  = BW'($urandom);
            step();
            check("req_hold_valid", o_mem_req_valid, 1);
            check("req_hold_addr", o_mem_req_address, req_addr_of(addr));
            check("req_hold_miss_ready", o_miss_ready, 0);
        end
        i_mem_req_ready = 1'b1;
        step();
        i_mem_req_ready  = 1'b0;
        i_mem_resp_valid = 1'b0;
        check("req_dropped", o_mem_req_valid, 0);
        for (int k = 0; k < NB; k++) begin
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            for (int g = 0; g < gap; g++) begin
                i_mem_resp_valid = 1'b0;
                step();
                check("no_write_in_gap", o_line_write_enable, 0);
            end
            i_mem_resp_valid = 1'b1;
            i_mem_resp_data  = beats[k];
            step();
            if (k < NB - 1) check("no_early_write", o_line_write_enable, 0);
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
            check("crit_valid", o_critical_valid, (k == 0) ? 1 : 0);
            if (k == 0) check("crit_data", o_critical_data, beats[0]);
`endif
        end
        i_mem_resp_valid = 1'b0;
        check("write_enable", o_line_write_enable, 1);
        check("refill_done", o_refill_done, 1);
        check("write_miss_ready", o_miss_ready, 0);
        check("write_index", o_line_write_address, index_of(addr));
        check("write_line", o_line_data, exp_line);
`ifndef ICACHE_CRITICAL_WORD_FIRST_EN
        check("crit_valid_off", o_critical_valid, 0);
        check("crit_data_off", o_critical_data, 0);
`endif
        step();
        check("after_we", o_line_write_enable, 0);
        check("after_done", o_refill_done, 0);
        check("after_miss_ready", o_miss_ready, 1);
        check("write_count", wr_count, wr0 + 1);
        $display("refill addr=%08h req=%08h idx=%03h start_slot=%0d writes=%0d",
                 addr, req_addr_of(addr), index_of(addr), s, wr_count - wr0);
    endtask

    initial begin
        logic [AW-1:0] ra;
        int wr0;
        i_reset_n        = 1'b0;
        i_miss_valid     = 1'b0;
        i_miss_address   = '0;
        i_mem_req_ready  = 1'b0;
        i_mem_resp_valid = 1'b0;
        i_mem_resp_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        i_reset_n = 1'b1;
        step();
        check("post_reset_miss_ready", o_miss_ready, 1);
        check("post_reset_no_write", wr_count, 0);

        // In-order fill with immediate ready; write falls in cycle 18.
        run_refill(32'h0000_1234, 0, 0, 0, 0, '0, 1);

        // Slow ready, gapped beats, beats presented during REQUEST.
        run_refill(32'h0000_5A7C, 5, 3, 0, 0, '0, 0);

        // Requester keeps MISS_VALID high during a refill.
        run_refill(32'h0000_3000, 2, 1, 0, 1, 32'h0000_4440, 0);
        run_refill(32'h0000_4440, 0, 2, 0, 0, '0, 0);

        // Stray beats in IDLE must not be counted.
        i_mem_resp_valid = 1'b1;
        i_mem_resp_data  = 32'hBAD0_0001;
        repeat (3) step();
        check("stray_no_request", o_mem_req_valid, 0);
        run_refill(32'h0000_6600, 1, 0, 1, 0, '0, 0);

        // Reset pulsed after beat 7 abandons the refill.
        wr0 = wr_count;
        i_miss_valid   = 1'b1;
        i_miss_address = 32'h0000_2468;
        step();
        i_miss_valid    = 1'b0;
        i_mem_req_ready = 1'b1;
        step();
        i_mem_req_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            i_mem_resp_valid = 1'b1;
            i_mem_resp_data  = BW'($urandom);
            step();
        end
        i_reset_n = 1'b0;
        #1;
        check_idle_outputs("mid_reset");
        step();
        check_idle_outputs("mid_reset_held");
        i_reset_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            i_mem_resp_valid = 1'b1;
            i_mem_resp_data  = BW'($urandom);
            step();
            check("after_reset_no_write", o_line_write_enable, 0);
        end
        i_mem_resp_valid = 1'b0;
        check("after_reset_write_count", wr_count, wr0);
        check("after_reset_miss_ready", o_miss_ready, 1);
        run_refill(32'h0000_2468, 0, 1, 0, 0, '0, 0);

        // Critical beat 14 first; line must equal the in-order line.
        run_refill(32'h0000_1238, 0, 0, 0, 0, '0, 1);

        // Index wrap at the top of the address space and back to zero.
        run_refill(32'hFFFF_FFC0, 0, 0, 0, 0, '0, 0);
        run_refill(32'h0000_8000, 1, 1, 0, 0, '0, 0);

        // Randomized refills.
        for (int r = 0; r < 6; r++) begin
            ra = AW'($urandom);
            run_refill(ra, int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 0, '0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/icache_line_refill.md
# icache_line_refill

Instruction-cache refill controller. Accepts a line-miss request from the cache control logic and issues one line-read request to the next-level memory. It then assembles the returned narrow beats into a full cache line and writes that line into the cache data memory in a single-cycle write. It sits directly upstream of the cache's line-wide dual-port data memory and drives that memory's write port.

## Interface
- LINE_WIDTH, 512, cache line width in bits (data memory word width)
- BEAT_WIDTH, 32, memory response beat width; LINE_WIDTH must be an integer multiple of it
- ADDR_WIDTH, 32, byte address width
- LINE_DEPTH, 512, number of lines in the data memory
- Derived values:
  - BEATS = LINE_WIDTH/BEAT_WIDTH (16 by default)
  - OFFSET_W = $clog2(LINE_WIDTH/8) (6)
  - INDEX_W = $clog2(LINE_DEPTH) (9)

Ports:
- CLK  in  1  clock; all logic on the rising edge
- RESET_N  in  1  asynchronous, active-low reset
- MISS_VALID  in  1  miss request
- MISS_ADDRESS  in  ADDR_WIDTH  byte address that missed
- MISS_READY  out  1  controller idle; request accepted when MISS_VALID & MISS_READY
- MEM_REQ_VALID  out  1  line-read request to memory
- MEM_REQ_ADDRESS  out  ADDR_WIDTH  request address
- MEM_REQ_READY  in  1  memory accepts request
- MEM_RESP_VALID  in  1  response beat valid (no backpressure)
- MEM_RESP_DATA  in  BEAT_WIDTH  response beat
- LINE_WRITE_ENABLE  out  1  data-memory write strobe
- LINE_WRITE_ADDRESS  out  INDEX_W  data-memory line index
- LINE_DATA  out  LINE_WIDTH  assembled line
- REFILL_DONE  out  1  one-cycle pulse, coincident with the line write
- CRITICAL_VALID  out  1  critical-word forward strobe (see Configuration)
- CRITICAL_DATA  out  BEAT_WIDTH  critical word

## Operation
- FSM states: IDLE, REQUEST, RECEIVE, WRITE.
- IDLE:
  - MISS_READY=1.
  - On handshake, latch MISS_ADDRESS; the line address is the address with bits [OFFSET_W-1:0] cleared.
  - Go to REQUEST.
- REQUEST:
  - MEM_REQ_VALID=1 with a stable MEM_REQ_ADDRESS until MEM_REQ_READY is sampled high.
  - Then go to RECEIVE with the beat counter loaded.
- RECEIVE:
  - Each MEM_RESP_VALID cycle stores MEM_RESP_DATA into line-buffer slot `beat_ptr`, i.e. bits [beat_ptr*BEAT_WIDTH +: BEAT_WIDTH]. Slot 0 is the least significant.
  - `beat_ptr` increments modulo BEATS.
  - A separate received-count reaching BEATS moves the FSM to WRITE.
  - MEM_RESP_VALID gaps are allowed; the FSM waits in RECEIVE.
- WRITE (exactly one cycle):
  - LINE_WRITE_ENABLE=1, REFILL_DONE=1.
  - LINE_WRITE_ADDRESS = latched address bits [OFFSET_W +: INDEX_W].
  - LINE_DATA = line buffer.
  - Next state is IDLE.
- LINE_DATA is driven from the line buffer at all times; it is only meaningful when LINE_WRITE_ENABLE=1.
- MEM_RESP_VALID outside RECEIVE is ignored and not counted.
- MISS_VALID while not IDLE: MISS_READY=0, so the request is held by the requester and not accepted.
- Reset values:
  - State IDLE.
  - MISS_READY=1 during and after reset.
  - All other outputs 0.
  - Line buffer, counters and latched address 0.
- Reset asserted mid-refill:
  - Refill is abandoned with no line write.
  - Beats still arriving after release are ignored, since the FSM is in IDLE.

## Timing
- Miss accepted at edge 0 → MEM_REQ_VALID high in cycle 1.
- MEM_REQ_READY high in cycle 1 → first beat may be accepted in cycle 2.
- Last beat sampled in cycle t → LINE_WRITE_ENABLE and REFILL_DONE high in cycle t+1 → MISS_READY high in cycle t+2.
- Minimum miss-to-write latency with back-to-back beats and immediate ready: 18 cycles (write in cycle 18).
- The data memory captures the line on the edge ending the WRITE cycle. A read of the same index is valid from the following cycle per the memory's read latency.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.

## Configuration
- Macro: ICACHE_CRITICAL_WORD_FIRST_EN.
- When defined:
  - MEM_REQ_ADDRESS = miss address aligned to a beat boundary. Memory returns the critical beat first, then wraps modulo BEATS.
  - `beat_ptr` is loaded with the critical beat offset, so slots fill wrapping past BEATS-1 to 0.
  - On the first accepted beat, CRITICAL_VALID=1 for one cycle, with CRITICAL_DATA = that beat, registered so it appears the cycle after sampling.
- When not defined:
  - MEM_REQ_ADDRESS = line-aligned address; `beat_ptr` starts at 0.
  - CRITICAL_VALID and CRITICAL_DATA are constant 0.

## Test plan
- Reset then miss at 0x0000_1234, ready immediate, beats 0x1000+i on 16 consecutive cycles → MEM_REQ_ADDRESS=0x0000_1200; one write at index 0x048 with LINE_DATA slot i = 0x1000+i; REFILL_DONE in cycle 18; MISS_READY back in cycle 19.
- MEM_REQ_READY held low 5 cycles and beats with random 0-3 cycle gaps → request stays stable; exactly one write after the 16th beat; beats presented during REQUEST are ignored.
- MISS_VALID held high during a refill plus a stray MEM_RESP_VALID in IDLE → second miss accepted only when MISS_READY=1 after the write; the stray beat is not counted.
- RESET_N pulsed low after beat 7 → no LINE_WRITE_ENABLE; all outputs 0 and MISS_READY=1 while in reset; the next full refill writes a correct line.
- With ICACHE_CRITICAL_WORD_FIRST_EN, miss 0x0000_1238 (beat 14), beats returned as 14,15,0..13 → MEM_REQ_ADDRESS=0x0000_1238; CRITICAL_VALID one cycle with beat 14 data; final line identical to in-order fill.
- Address index wrap: miss 0xFFFF_FFC0 → index 0x1FF written; a following miss at 0x0000_8000 → index 0x000.
